// File: rtl/game_pkg.sv
// Shared types and constants for the VGA game: coordinate width, FSM states, play-field border.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int DEF_BORDER_TOP    = 8;
    localparam int DEF_BORDER_BOTTOM = 472;
    localparam int DEF_BORDER_LEFT   = 8;
    localparam int DEF_BORDER_RIGHT  = 632;

endpackage

// File: rtl/axis_step_clamp.sv
// One-axis move of the player's low edge by STEP, clamped so the square stays inside [lo, hi].
// Latency: combinational.
// Backpressure: none.
module axis_step_clamp
    import game_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int STEP = 1
) (
    input  coord_t pos,
    input  logic   dec,
    input  logic   inc,
    input  coord_t lo,
    input  coord_t hi,
    output coord_t pos_nxt,
    output logic   at_low,
    output logic   at_high
);

    localparam coord_t SZ_M1 = coord_t'(SIZE - 1);
    localparam coord_t STP   = coord_t'(STEP);

    always_comb begin
        pos_nxt = pos;
        if (dec && !inc) begin
            // Compare before subtracting so a position near zero cannot wrap.
            if (pos < lo + STP) begin
                pos_nxt = lo;
            end else begin
                pos_nxt = pos - STP;
            end
        end else if (inc && !dec) begin
            if (pos + SZ_M1 + STP > hi) begin
                pos_nxt = hi - SZ_M1;
            end else begin
                pos_nxt = pos + STP;
            end
        end
    end

    assign at_low  = (pos_nxt == lo);
    assign at_high = (pos_nxt + SZ_M1 == hi);

endmodule

// File: rtl/player_motion_ctrl.sv
// Player position, border collision and hit/flash/respawn/game-over sequencing, one move per frame.
// Latency: position and hit pulse update on the frame_tick edge; edges are combinational from x/y.
// Backpressure: none; frame_tick and buttons are sampled every clk.
module player_motion_ctrl
    import game_pkg::*;
#(
    parameter int X_START       = 320,
    parameter int Y_START       = 240,
    parameter int SIZE          = 16,
    parameter int STEP          = 1,
    parameter int BORDER_TOP    = DEF_BORDER_TOP,
    parameter int BORDER_BOTTOM = DEF_BORDER_BOTTOM,
    parameter int BORDER_LEFT   = DEF_BORDER_LEFT,
    parameter int BORDER_RIGHT  = DEF_BORDER_RIGHT,
    parameter int FLASH_FRAMES  = 60,
    parameter int LIVES_INIT    = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_start,
    output logic [9:0]   play_top,
    output logic [9:0]   play_bottom,
    output logic [9:0]   play_left,
    output logic [9:0]   play_right,
    output logic         hit,
    output logic         flash,
    output logic [1:0]   lives,
    output logic         game_over,
    output logic [1:0]   state
);

    localparam int CNT_W = ($clog2(FLASH_FRAMES + 1) < 4) ? 4 : $clog2(FLASH_FRAMES + 1);

    localparam coord_t           X0         = coord_t'(X_START);
    localparam coord_t           Y0         = coord_t'(Y_START);
    localparam coord_t           SZ_M1      = coord_t'(SIZE - 1);
    localparam logic [1:0]       LIVES0     = 2'(LIVES_INIT);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES);

    state_t           state_q, state_d;
    coord_t           x_q, x_d, y_q, y_d;
    logic [1:0]       lives_q, lives_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             start_q, start_d;

    coord_t x_nxt, y_nxt;
    logic   x_at_low, x_at_high, y_at_low, y_at_high;
    logic   start_rise, collide;

    axis_step_clamp #(.SIZE(SIZE), .STEP(STEP)) u_x_axis (
        .pos     (x_q),
        .dec     (btn_left),
        .inc     (btn_right),
        .lo      (coord_t'(BORDER_LEFT)),
        .hi      (coord_t'(BORDER_RIGHT)),
        .pos_nxt (x_nxt),
        .at_low  (x_at_low),
        .at_high (x_at_high)
    );

    axis_step_clamp #(.SIZE(SIZE), .STEP(STEP)) u_y_axis (
        .pos     (y_q),
        .dec     (btn_up),
        .inc     (btn_down),
        .lo      (coord_t'(BORDER_TOP)),
        .hi      (coord_t'(BORDER_BOTTOM)),
        .pos_nxt (y_nxt),
        .at_low  (y_at_low),
        .at_high (y_at_high)
    );

    assign start_rise = btn_start & ~start_q;
    assign collide    = x_at_low | x_at_high | y_at_low | y_at_high;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        start_d = btn_start;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_tick) begin
                    x_d = x_nxt;
                    y_d = y_nxt;
                    if (collide) begin
                        state_d = ST_HIT;
                        hit_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == FLASH_LAST) begin
                        if (lives_q == 2'd1) begin
                            lives_d = 2'd0;
                            state_d = ST_OVER;
                        end else begin
                            lives_d = lives_q - 2'd1;
                            x_d     = X0;
                            y_d     = Y0;
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    lives_d = LIVES0;
                    x_d     = X0;
                    y_d     = Y0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= X0;
            y_q     <= Y0;
            lives_q <= LIVES0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            start_q <= start_d;
        end
    end

    assign play_top    = y_q;
    assign play_bottom = y_q + SZ_M1;
    assign play_left   = x_q;
    assign play_right  = x_q + SZ_M1;
    assign hit         = hit_q;
    // Flash is only meaningful while HIT, so leaving HIT clears it with no extra flop.
    assign flash       = (state_q == ST_HIT) & cnt_q[3];
    assign lives       = lives_q;
    assign game_over   = (state_q == ST_OVER);
    assign state       = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: default instance plus a STEP=5 instance started 2 px off the right border.
module tb_player_motion_ctrl;

    logic clk = 1'b0;
    logic reset, frame_tick, btn_up, btn_down, btn_left, btn_right, btn_start;

    logic [9:0] top0, bot0, lft0, rgt0, top1, bot1, lft1, rgt1;
    logic       hit0, flash0, go0, hit1, flash1, go1;
    logic [1:0] lives0, st0, lives1, st1;
    logic [46:0] obs0, obs1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one slot per DUT, state codes IDLE=0 RUN=1 HIT=2 OVER=3.
    int mx[2], my[2], ml[2], ms[2], mc[2], mh[2];
    int m_sprev;

    always #5 clk = ~clk;

    player_motion_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start),
        .play_top(top0), .play_bottom(bot0), .play_left(lft0), .play_right(rgt0),
        .hit(hit0), .flash(flash0), .lives(lives0), .game_over(go0), .state(st0)
    );

    player_motion_ctrl #(.STEP(5), .X_START(615)) dut5 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start),
        .play_top(top1), .play_bottom(bot1), .play_left(lft1), .play_right(rgt1),
        .hit(hit1), .flash(flash1), .lives(lives1), .game_over(go1), .state(st1)
    );

    assign obs0 = {top0, bot0, lft0, rgt0, hit0, flash0, lives0, go0, st0};
    assign obs1 = {top1, bot1, lft1, rgt1, hit1, flash1, lives1, go1, st1};

    function automatic int stp(int k);
        return (k == 1) ? 5 : 1;
    endfunction

    function automatic int xs(int k);
        return (k == 1) ? 615 : 320;
    endfunction

    function automatic logic [46:0] obs_of(int k);
        return (k == 1) ? obs1 : obs0;
    endfunction

    function automatic logic [46:0] exp_vec(int k);
        logic fl;
        fl = (ms[k] == 2) && (((mc[k] / 8) % 2) == 1);
        return {10'(my[k]), 10'(my[k] + 15), 10'(mx[k]), 10'(mx[k] + 15),
                1'(mh[k]), fl, 2'(ml[k]), (ms[k] == 3), 2'(ms[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = xs(k); my[k] = 240; ml[k] = 3; ms[k] = 0; mc[k] = 0; mh[k] = 0;
        end
        m_sprev = 0;
    endtask

    task automatic model_update();
        int rise, dx, dy, nx, ny;
        rise = (btn_start && !m_sprev) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0;
            case (ms[k])
                0: if (rise != 0) ms[k] = 1;
                1: if (frame_tick) begin
                    dx = (btn_right && !btn_left) ? stp(k) : (btn_left && !btn_right) ? -stp(k) : 0;
                    dy = (btn_down && !btn_up) ? stp(k) : (btn_up && !btn_down) ? -stp(k) : 0;
                    nx = mx[k] + dx;
                    ny = my[k] + dy;
                    if (nx < 8) nx = 8;
                    if (nx + 15 > 632) nx = 632 - 15;
                    if (ny < 8) ny = 8;
                    if (ny + 15 > 472) ny = 472 - 15;
                    mx[k] = nx;
                    my[k] = ny;
                    if (nx == 8 || nx + 15 == 632 || ny == 8 || ny + 15 == 472) begin
                        ms[k] = 2; mh[k] = 1; mc[k] = 0;
                    end
                end
                2: if (frame_tick) begin
                    mc[k] = mc[k] + 1;
                    if (mc[k] == 60) begin
                        if (ml[k] == 1) begin
                            ml[k] = 0; ms[k] = 3;
                        end else begin
                            ml[k] = ml[k] - 1; mx[k] = xs(k); my[k] = 240; ms[k] = 1;
                        end
                    end
                end
                default: if (rise != 0) begin
                    ml[k] = 3; mx[k] = xs(k); my[k] = 240; ms[k] = 1;
                end
            endcase
        end
        m_sprev = btn_start ? 1 : 0;
    endtask

    // One clock with frame_tick=tk; returns at the following negedge.
    task automatic step(input logic tk);
        frame_tick = tk;
        @(posedge clk);
        if (reset) model_reset(); else model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_start = 0;
        model_reset();
        step(0); step(0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs_of(k) !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL reset_model dut%0d got=%h exp=%h", k, obs_of(k), exp_vec(k));
            end
        end
        vectors++;
        if ({top0, bot0, lft0, rgt0} !== {10'd240, 10'd255, 10'd320, 10'd335} ||
            st0 !== 2'd0 || lives0 !== 2'd3 || hit0 !== 1'b0 || flash0 !== 1'b0 || go0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values got=%0d/%0d/%0d/%0d st=%0d lives=%0d exp=240/255/320/335 st=0 lives=3",
                     top0, bot0, lft0, rgt0, st0, lives0);
        end
        reset = 1'b0;
        step(0);
    endtask

    task automatic test_start();
        // Start and frame_tick together in IDLE: start wins, no move.
        btn_start = 1; btn_right = 1;
        step(1);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs_of(k) !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL start_model dut%0d got=%h exp=%h", k, obs_of(k), exp_vec(k));
            end
        end
        vectors++;
        if (st0 !== 2'd1 || lft0 !== 10'd320 || rgt1 !== 10'd630) begin
            miscompares++;
            $display("FAIL start_run got st=%0d left=%0d right5=%0d exp st=1 left=320 right5=630", st0, lft0, rgt1);
        end
        btn_start = 0; btn_right = 0;
        for (int i = 0; i < 4; i++) step(0);
        vectors++;
        if ({top0, bot0, lft0, rgt0} !== {10'd240, 10'd255, 10'd320, 10'd335}) begin
            miscompares++;
            $display("FAIL start_no_tick_hold got=%0d/%0d/%0d/%0d exp=240/255/320/335", top0, bot0, lft0, rgt0);
        end
    endtask

    task automatic test_mixed_buttons();
        btn_left = 1; btn_right = 1; btn_up = 1;
        for (int i = 1; i <= 5; i++) begin
            btn_start = (i == 3);
            for (int j = 0; j < 2; j++) begin
                step(j == 0);
                for (int k = 0; k < 2; k++) begin
                    vectors++;
                    if (obs_of(k) !== exp_vec(k)) begin
                        miscompares++;
                        $display("FAIL mixed_model dut%0d tick%0d got=%h exp=%h", k, i, obs_of(k), exp_vec(k));
                    end
                end
            end
        end
        btn_start = 0;
        vectors++;
        if (lft0 !== 10'd320 || top0 !== 10'd235 || st0 !== 2'd1 || hit0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mixed_result got left=%0d top=%0d st=%0d exp left=320 top=235 st=1", lft0, top0, st0);
        end
        btn_left = 0; btn_right = 0; btn_up = 0;
    endtask

    task automatic test_right_collision();
        int hits;
        hits = 0;
        btn_right = 1;
        for (int i = 1; i <= 297; i++) begin
            for (int j = 0; j < 2; j++) begin
                step(j == 0);
                for (int k = 0; k < 2; k++) begin
                    vectors++;
                    if (obs_of(k) !== exp_vec(k)) begin
                        miscompares++;
                        $display("FAIL right_model dut%0d tick%0d got=%h exp=%h", k, i, obs_of(k), exp_vec(k));
                    end
                end
                if (hit0) hits++;
                if (i == 1 && j == 0) begin
                    vectors++;
                    if (rgt1 !== 10'd632 || hit1 !== 1'b1) begin
                        miscompares++;
                        $display("FAIL step5_clamp got right=%0d hit=%0d exp right=632 hit=1", rgt1, hit1);
                    end
                end
                if (i == 297 && j == 0) begin
                    vectors++;
                    if (rgt0 !== 10'd632 || hit0 !== 1'b1 || st0 !== 2'd2 || lives0 !== 2'd3) begin
                        miscompares++;
                        $display("FAIL right_hit got right=%0d hit=%0d st=%0d lives=%0d exp 632 1 2 3",
                                 rgt0, hit0, st0, lives0);
                    end
                end
            end
        end
        vectors++;
        if (hits != 1) begin
            miscompares++;
            $display("FAIL hit_pulse_width got=%0d exp=1", hits);
        end
        btn_right = 0;
    endtask

    task automatic test_hit_flash();
        for (int i = 1; i <= 60; i++) begin
            step(1);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs_of(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL flash_model dut%0d frame%0d got=%h exp=%h", k, i, obs_of(k), exp_vec(k));
                end
            end
            if (i < 60) begin
                vectors++;
                if (flash0 !== 1'((i / 8) % 2) || st0 !== 2'd2) begin
                    miscompares++;
                    $display("FAIL flash_bit frame%0d got flash=%0d st=%0d exp flash=%0d st=2", i, flash0, st0, (i / 8) % 2);
                end
            end
            step(0);
        end
        vectors++;
        if (st0 !== 2'd1 || lives0 !== 2'd2 || flash0 !== 1'b0 ||
            {top0, bot0, lft0, rgt0} !== {10'd240, 10'd255, 10'd320, 10'd335}) begin
            miscompares++;
            $display("FAIL respawn got st=%0d lives=%0d flash=%0d edges=%0d/%0d/%0d/%0d exp 1 2 0 240/255/320/335",
                     st0, lives0, flash0, top0, bot0, lft0, rgt0);
        end
    endtask

    task automatic test_game_over();
        int n;
        n = 0;
        btn_up = 1;
        while (!go0 && n < 1000) begin
            for (int j = 0; j < 2; j++) begin
                step(j == 0);
                for (int k = 0; k < 2; k++) begin
                    vectors++;
                    if (obs_of(k) !== exp_vec(k)) begin
                        miscompares++;
                        $display("FAIL over_model dut%0d tick%0d got=%h exp=%h", k, n, obs_of(k), exp_vec(k));
                    end
                end
            end
            n++;
        end
        vectors++;
        if (go0 !== 1'b1 || lives0 !== 2'd0 || st0 !== 2'd3) begin
            miscompares++;
            $display("FAIL game_over got go=%0d lives=%0d st=%0d after %0d ticks exp go=1 lives=0 st=3",
                     go0, lives0, st0, n);
        end
        btn_up = 0;
        btn_start = 1;
        step(0);
        btn_start = 0;
        vectors++;
        if (lives0 !== 2'd3 || st0 !== 2'd1 || go0 !== 1'b0) begin
            miscompares++;
            $display("FAIL restart got lives=%0d st=%0d go=%0d exp lives=3 st=1 go=0", lives0, st0, go0);
        end
        step(0);
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        btn_right = 1;
        while (st0 != 2'd2 && n < 400) begin
            step(1); step(0);
            n++;
        end
        btn_right = 0;
        for (int i = 0; i < 30; i++) begin
            step(1); step(0);
        end
        vectors++;
        if (st0 !== 2'd2 || flash0 !== 1'b1 || lives0 !== 2'd3) begin
            miscompares++;
            $display("FAIL pre_reset_hit got st=%0d flash=%0d lives=%0d exp st=2 flash=1 lives=3", st0, flash0, lives0);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (st0 !== 2'd0 || flash0 !== 1'b0 || hit0 !== 1'b0 || lives0 !== 2'd3 ||
            {top0, bot0, lft0, rgt0} !== {10'd240, 10'd255, 10'd320, 10'd335}) begin
            miscompares++;
            $display("FAIL async_reset got st=%0d flash=%0d hit=%0d lives=%0d edges=%0d/%0d/%0d/%0d exp 0 0 0 3 240/255/320/335",
                     st0, flash0, hit0, lives0, top0, bot0, lft0, rgt0);
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs_of(k) !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL async_reset_model dut%0d got=%h exp=%h", k, obs_of(k), exp_vec(k));
            end
        end
        step(0);
        reset = 1'b0;
        step(0);
    endtask

    task automatic test_random();
        logic [3:0] pref, pick;
        pref = 4'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) pref = 4'($urandom_range(0, 15));
            pick = ($urandom_range(0, 3) != 0) ? pref : 4'($urandom_range(0, 15));
            {btn_up, btn_down, btn_left, btn_right} = pick;
            btn_start = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 599) == 0);
            step($urandom_range(0, 1) == 1);
            reset = 1'b0;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs_of(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random_model dut%0d cyc%0d got=%h exp=%h", k, c, obs_of(k), exp_vec(k));
                end
            end
        end
        {btn_up, btn_down, btn_left, btn_right, btn_start} = 5'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_mixed_buttons();
        test_right_collision();
        test_hit_flash();
        test_game_over();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Game-level sequencer for the player rectangle in the VGA game.
- Advances the player position once per video frame from the direction buttons, clamps it at the play-field border, and flags a collision when any player edge reaches its border edge.
- Runs the resulting hit / flash / respawn / game-over sequence.
- Feeds player edge coordinates to the renderer and to the collision logic.

Parameters:
- X_START, 320, reset/respawn left edge (pixels)
- Y_START, 240, reset/respawn top edge (pixels)
- SIZE, 16, player square side length (pixels)
- STEP, 1, pixels moved per frame per axis
- BORDER_TOP, 8, top border line y
- BORDER_BOTTOM, 472, bottom border line y
- BORDER_LEFT, 8, left border line x
- BORDER_RIGHT, 632, right border line x
- FLASH_FRAMES, 60, frames spent in HIT before respawn
- LIVES_INIT, 3, lives at reset and at restart (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-clk pulse per video frame
- btn_up, btn_down, btn_left, btn_right  in  1 each  synchronized, debounced levels
- btn_start  in  1  synchronized, debounced level
- play_top, play_bottom, play_left, play_right  out  10 each  player edges
- hit  out  1  one-clk collision pulse
- flash  out  1  player blink enable for renderer
- lives  out  2  remaining lives
- game_over  out  1  high in OVER
- state  out  2  IDLE=0, RUN=1, HIT=2, OVER=3

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - x=X_START, y=Y_START (play_top=240, play_bottom=255, play_left=320, play_right=335)
  - lives=LIVES_INIT, state=IDLE
  - hit=0, flash=0, game_over=0
  - frame counter=0, start edge register=0
- Edges are combinational from the x/y registers:
  - play_top=y, play_bottom=y+SIZE-1
  - play_left=x, play_right=x+SIZE-1
  - All arithmetic is 10-bit unsigned.
- Start edge: start_rise = btn_start & ~start_q, where start_q is registered every clk.
- IDLE:
  - Position is frozen.
  - start_rise -> RUN on the next edge.
- RUN:
  - Position updates only on clk edges where frame_tick=1.
  - Per axis: up-only gives y-STEP; down-only gives y+STEP; both or neither gives no change. Same rule for left/right on x. Diagonal moves are allowed.
  - Clamp on top/left: if y-STEP < BORDER_TOP, y=BORDER_TOP (x likewise). Compare before subtracting to avoid underflow.
  - Clamp on bottom/right: if y+SIZE-1+STEP > BORDER_BOTTOM, then y=BORDER_BOTTOM-SIZE+1 (x likewise with BORDER_RIGHT).
  - Collision is evaluated on the new position: top==BORDER_TOP, bottom==BORDER_BOTTOM, left==BORDER_LEFT or right==BORDER_RIGHT.
  - On collision, on the same edge as the position write: state<=HIT, hit<=1 for exactly one clk, frame counter<=0.
- HIT:
  - Position is frozen and buttons are ignored.
  - Frame counter increments on each frame_tick.
  - flash = frame counter bit 3 (toggles every 8 frames).
  - On the frame_tick that brings the counter to FLASH_FRAMES:
    - flash<=0
    - if lives==1: lives<=0, state<=OVER
    - else: lives<=lives-1, x/y<=start values, state<=RUN
- OVER:
  - game_over=1 and position is frozen.
  - start_rise -> lives<=LIVES_INIT, x/y<=start values, state<=RUN.
- frame_tick and start_rise in the same clk:
  - In IDLE: start wins, no move that cycle.
  - In RUN/HIT: start is ignored.
- Reset asserted mid-HIT or mid-move returns all registers to reset values immediately; no pending hit pulse survives.
- hit never asserts outside the RUN->HIT transition.
- Latency: button level to position change is ≤1 frame. Collision to hit pulse is 0 clk after the position write.

Decomposition:
- Shared package game_pkg:
  - state encoding constants (ST_IDLE, ST_RUN, ST_HIT, ST_OVER)
  - border coordinate constants
  - coordinate width (10)
- One natural combinational sub-module, axis_step_clamp:
  - inputs: position, dec/inc buttons, low bound, high bound, SIZE, STEP
  - outputs: next position, at_low, at_high
  - instantiated twice (x, y)
- The FSM, frame counter and lives stay in player_motion_ctrl.

Test Plan:
- Reset then btn_start pulse -> state IDLE->RUN on the next clk. Edges stay 240/255/320/335 until the first frame_tick.
- RUN, btn_right held, 297 frame_ticks -> play_right 335->632; hit=1 for exactly 1 clk on the 297th; state=HIT; lives still 3.
- RUN, btn_left+btn_right+btn_up held, 5 frame_ticks -> x unchanged at 320, y 240->235, no hit.
- STEP=5, x placed so play_right=630, btn_right, 1 frame_tick -> play_right clamped to 632, hit=1.
- HIT, 60 frame_ticks -> flash toggles every 8 frames, then lives=2, edges back to 240/255/320/335, state=RUN. Third collision -> lives=0, game_over=1, state=OVER. Start pulse -> lives=3, state=RUN.
- Reset asserted asynchronously mid-HIT (frame 30) -> state=IDLE, flash=0, hit=0, lives=3, start edges, all without waiting for a clk edge.
